// File: rtl/grad_eval_engine.sv
// Evaluates a separable quadratic bowl and its scaled gradient over four Q8.8 axes.
// A single shared multiplier is time-multiplexed: square then step for each axis.
module grad_eval_engine #(
  parameter logic signed [31:0] LEARNING_RATE_A = 32'h0000_0030,
  parameter logic signed [31:0] LEARNING_RATE_B = 32'h0000_0030,
  parameter logic signed [31:0] LEARNING_RATE_C = 32'h0000_0030,
  parameter logic signed [31:0] LEARNING_RATE_D = 32'h0000_0030,
  parameter logic signed [15:0] TARGET_A = 16'h0100,
  parameter logic signed [15:0] TARGET_B = 16'hFE00,
  parameter logic signed [15:0] TARGET_C = 16'h0300,
  parameter logic signed [15:0] TARGET_D = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_func,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic [15:0] c_in,
  input  logic [15:0] d_in,
  output logic [31:0] value,
  output logic [15:0] a_diff_out,
  output logic [15:0] b_diff_out,
  output logic [15:0] c_diff_out,
  output logic [15:0] d_diff_out,
  output logic        func_done,
  output logic        overflow
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]         state;
  logic [2:0]         step;
  logic signed [15:0] xa, xb, xc, xd;
  logic [31:0]        acc;
  logic               ovf_pend;
  logic [15:0]        da_p, db_p, dc_p;

  logic signed [15:0] x_sel, t_sel;
  logic signed [31:0] lr_sel;
  logic signed [16:0] e;
  logic signed [17:0] mul_a;
  logic signed [31:0] mul_b;
  logic signed [49:0] prod, shifted;
  logic [15:0]        sat_val;
  logic               sat_hit;

  // step[2:1] picks the axis, step[0] picks square (0) or gradient step (1)
  always_comb begin
    x_sel  = xa;
    t_sel  = TARGET_A;
    lr_sel = LEARNING_RATE_A;
    case (step[2:1])
      2'd1: begin x_sel = xb; t_sel = TARGET_B; lr_sel = LEARNING_RATE_B; end
      2'd2: begin x_sel = xc; t_sel = TARGET_C; lr_sel = LEARNING_RATE_C; end
      2'd3: begin x_sel = xd; t_sel = TARGET_D; lr_sel = LEARNING_RATE_D; end
      default: ;
    endcase
  end

  assign e       = {x_sel[15], x_sel} - {t_sel[15], t_sel};
  assign mul_a   = step[0] ? {e, 1'b0} : {e[16], e};
  assign mul_b   = step[0] ? lr_sel : {{15{e[16]}}, e};
  assign prod    = mul_a * mul_b;
  assign shifted = prod >>> 8;

  always_comb begin
    sat_hit = 1'b0;
    sat_val = shifted[15:0];
    if (shifted > 50'sd32767) begin
      sat_hit = 1'b1;
      sat_val = 16'h7FFF;
    end else if (shifted < -50'sd32768) begin
      sat_hit = 1'b1;
      sat_val = 16'h8000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step       <= 3'd0;
      xa         <= '0;
      xb         <= '0;
      xc         <= '0;
      xd         <= '0;
      acc        <= '0;
      ovf_pend   <= 1'b0;
      da_p       <= '0;
      db_p       <= '0;
      dc_p       <= '0;
      value      <= '0;
      a_diff_out <= '0;
      b_diff_out <= '0;
      c_diff_out <= '0;
      d_diff_out <= '0;
      func_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_func) begin
          xa       <= a_in;
          xb       <= b_in;
          xc       <= c_in;
          xd       <= d_in;
          acc      <= '0;
          ovf_pend <= 1'b0;
          step     <= 3'd0;
          state    <= COMPUTE;
        end
        COMPUTE: begin
          step <= step + 3'd1;
          if (!step[0]) acc <= acc + shifted[31:0];
          else begin
            ovf_pend <= ovf_pend | sat_hit;
            case (step[2:1])
              2'd0: da_p <= sat_val;
              2'd1: db_p <= sat_val;
              2'd2: dc_p <= sat_val;
              default: ;
            endcase
          end
          // last step: axis d's step goes straight to the output with everything else
          if (step == 3'd7) begin
            value      <= acc;
            a_diff_out <= da_p;
            b_diff_out <= db_p;
            c_diff_out <= dc_p;
            d_diff_out <= sat_val;
            overflow   <= ovf_pend | sat_hit;
            func_done  <= 1'b1;
            step       <= 3'd0;
            state      <= DONE;
          end
        end
        DONE: if (!start_func) begin
          func_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grad_eval_engine.sv
// Randomized scoreboard bench for grad_eval_engine: two instances (default and a
// large axis-a step size) share stimulus and are checked against an arithmetic model.
module tb_grad_eval_engine;
  logic clk = 0, rst_n = 0, start_func = 0;
  logic [15:0] a_in = 0, b_in = 0, c_in = 0, d_in = 0;
  logic [31:0] val [2];
  logic [15:0] dif [2][4];
  logic        done [2], ovf [2];

  always #5 clk = ~clk;

  grad_eval_engine dut0 (
    .clk(clk), .rst_n(rst_n), .start_func(start_func),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .value(val[0]), .a_diff_out(dif[0][0]), .b_diff_out(dif[0][1]),
    .c_diff_out(dif[0][2]), .d_diff_out(dif[0][3]),
    .func_done(done[0]), .overflow(ovf[0]));

  grad_eval_engine #(.LEARNING_RATE_A(32'h0000_0400)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_func(start_func),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .value(val[1]), .a_diff_out(dif[1][0]), .b_diff_out(dif[1][1]),
    .c_diff_out(dif[1][2]), .d_diff_out(dif[1][3]),
    .func_done(done[1]), .overflow(ovf[1]));

  typedef struct packed {
    logic [31:0]      v;
    logic [3:0][15:0] d;
    logic             o;
  } res_t;

  res_t q0 [$];
  res_t q1 [$];
  int total = 0, bad = 0;
  logic [31:0] last_val = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // value = sum (x-T)^2, step = LR*2(x-T), both floored to Q24.8, step clamped to 16 bits
  function automatic res_t model(input logic [15:0] x0, x1, x2, x3, input longint lra);
    longint x [4];
    longint t [4];
    longint lr [4];
    longint e, p, sum;
    res_t r;
    x[0] = longint'($signed(x0)); x[1] = longint'($signed(x1));
    x[2] = longint'($signed(x2)); x[3] = longint'($signed(x3));
    t[0] = 256; t[1] = -512; t[2] = 768; t[3] = 0;
    lr[0] = lra; lr[1] = 48; lr[2] = 48; lr[3] = 48;
    sum = 0;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      e = x[k] - t[k];
      sum += (e * e) >>> 8;
      p = (2 * e * lr[k]) >>> 8;
      if (p > 32767) begin p = 32767; r.o = 1'b1; end
      else if (p < -32768) begin p = -32768; r.o = 1'b1; end
      r.d[k] = p[15:0];
    end
    r.v = sum[31:0];
    return r;
  endfunction

  // monitor: every rising func_done consumes one expected result per instance
  logic pd = 0;
  always @(negedge clk) begin
    if (done[0] && !pd) begin
      if (q0.size() == 0 || q1.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        res_t e0, e1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        chk("done1_sync", {31'd0, done[1]}, 1);
        chk("value0", val[0], e0.v);
        chk("value1", val[1], e1.v);
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("diff0_%0d", k), {16'd0, dif[0][k]}, {16'd0, e0.d[k]});
          chk($sformatf("diff1_%0d", k), {16'd0, dif[1][k]}, {16'd0, e1.d[k]});
        end
        chk("ovf0", {31'd0, ovf[0]}, {31'd0, e0.o});
        chk("ovf1", {31'd0, ovf[1]}, {31'd0, e1.o});
      end
    end
    pd <= done[0];
  end

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 4))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'($urandom_range(0, 1023)) - 16'd512;
      default: return 16'($urandom);
    endcase
  endfunction

  // mode 0: start held through DONE then dropped; mode 1: operands/start scrambled mid-compute
  task automatic run_eval(input logic [15:0] a, b, c, d, input int mode);
    int lat;
    res_t r0;
    @(negedge clk);
    a_in = a; b_in = b; c_in = c; d_in = d; start_func = 1;
    r0 = model(a, b, c, d, 48);
    q0.push_back(r0);
    q1.push_back(model(a, b, c, d, 1024));
    @(posedge clk);
    lat = -1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (done[0]) begin lat = cyc - 1; break; end
      chk("hold_value", val[0], last_val);
      if (mode == 1) begin
        a_in = rnd16(); b_in = rnd16(); c_in = rnd16(); d_in = rnd16();
        start_func = (cyc >= 8) ? 1'b0 : 1'($urandom_range(0, 1));
      end
    end
    chk("latency", lat, 8);
    last_val = r0.v;
    if (mode == 0) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("done_held", {31'd0, done[0]}, 1);
      end
    end
    start_func = 0;
    @(negedge clk);
    chk("done_dropped", {31'd0, done[0]}, 0);
  endtask

  initial begin
    #23;
    chk("rst_value", val[0], 0);
    chk("rst_diff_a", {16'd0, dif[0][0]}, 0);
    chk("rst_done", {31'd0, done[0]}, 0);
    chk("rst_ovf", {31'd0, ovf[0]}, 0);
    rst_n = 1;

    run_eval(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    chk("zero_value", val[0], 32'h0000_0E00);
    chk("zero_diff_a", {16'd0, dif[0][0]}, 32'h0000_FFA0);
    chk("zero_diff_b", {16'd0, dif[0][1]}, 32'h0000_00C0);
    chk("zero_diff_c", {16'd0, dif[0][2]}, 32'h0000_FEE0);
    chk("zero_diff_d", {16'd0, dif[0][3]}, 0);
    chk("zero_ovf", {31'd0, ovf[0]}, 0);

    run_eval(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1);
    chk("sat_diff_a", {16'd0, dif[1][0]}, 32'h0000_7FFF);
    chk("sat_ovf", {31'd0, ovf[1]}, 1);
    chk("sat_value", val[1], 32'h003F_0D02);

    run_eval(16'h0100, 16'hFE00, 16'h0300, 16'h0000, 0);
    chk("tgt_value", val[0], 0);
    chk("tgt_ovf", {31'd0, ovf[0]}, 0);
    for (int k = 0; k < 4; k++) chk("tgt_diff", {16'd0, dif[0][k]}, 0);

    for (int n = 0; n < 24; n++)
      run_eval(rnd16(), rnd16(), rnd16(), rnd16(), int'($urandom_range(0, 1)));

    // reset while axis c is being squared
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h8000; c_in = 16'h7FFF; d_in = 16'h4321; start_func = 1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 0; start_func = 0;
    #1;
    chk("mid_rst_value", val[0], 0);
    chk("mid_rst_diff_b", {16'd0, dif[0][1]}, 0);
    chk("mid_rst_done", {31'd0, done[0]}, 0);
    chk("mid_rst_ovf", {31'd0, ovf[1]}, 0);
    last_val = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, done[0]}, 0);
    end

    run_eval(16'hC000, 16'h0555, 16'hFFFF, 16'h8000, 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
